// File: rtl/prefix_adder_pkg.sv
// rtl/prefix_adder_pkg.sv - shared FSM state type and error-counter width for the adder BIST
package prefix_adder_pkg;

  localparam int ERR_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } bist_state_e;

endpackage

// File: rtl/prefix_adder_bist.sv
// rtl/prefix_adder_bist.sv - exhaustive sweep BIST for a WIDTH-bit combinational adder
// Vector counter is {a,b,cin}; each vector is driven SETTLE cycles, then checked for one cycle.
module prefix_adder_bist
  import prefix_adder_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic             op_cin,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic             fail_cin,
  output logic             fail_valid
);

  localparam int VEC_W = 2 * WIDTH + 1;
  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [VEC_W-1:0] VEC_MAX  = '1;
  localparam logic [VEC_W-1:0] VEC_ONE  = VEC_W'(1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);
  localparam logic [SET_W-1:0] SET_ONE  = SET_W'(1);

  bist_state_e      r_state;
  logic [VEC_W-1:0] r_vec;
  logic [SET_W-1:0] r_settle;
  logic [ERR_W-1:0] r_err;
  logic [WIDTH-1:0] r_fail_a;
  logic [WIDTH-1:0] r_fail_b;
  logic             r_fail_cin;
  logic             r_fail_valid;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;

  logic [WIDTH:0]   w_golden;
  logic [WIDTH:0]   w_observed;
  logic             w_mismatch;
  logic [ERR_W-1:0] w_err_next;
  logic [VEC_W-1:0] w_vec_next;

  // The counter register doubles as the operand register, so operands change on the edge that enters DRIVE.
  assign op_a   = r_vec[VEC_W-1 -: WIDTH];
  assign op_b   = r_vec[WIDTH -: WIDTH];
  assign op_cin = r_vec[0];

  assign w_golden   = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, op_cin};
  assign w_observed = {dut_cout, dut_sum};
  assign w_mismatch = (w_observed != w_golden);
  assign w_err_next = (w_mismatch && (r_err != ERR_MAX)) ? (r_err + ERR_ONE) : r_err;
  assign w_vec_next = r_vec + VEC_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_vec        <= '0;
      r_settle     <= '0;
      r_err        <= '0;
      r_fail_a     <= '0;
      r_fail_b     <= '0;
      r_fail_cin   <= 1'b0;
      r_fail_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state      <= DRIVE;
            r_vec        <= '0;
            r_settle     <= '0;
            r_err        <= '0;
            r_fail_a     <= '0;
            r_fail_b     <= '0;
            r_fail_cin   <= 1'b0;
            r_fail_valid <= 1'b0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
          end
        end
        DRIVE: begin
          if (r_settle == SET_LAST) begin
            r_settle <= '0;
            r_state  <= CHECK;
          end else begin
            r_settle <= r_settle + SET_ONE;
          end
        end
        CHECK: begin
          r_err <= w_err_next;
          if (w_mismatch && !r_fail_valid) begin
            r_fail_a     <= op_a;
            r_fail_b     <= op_b;
            r_fail_cin   <= op_cin;
            r_fail_valid <= 1'b1;
          end
          // Terminate on the final vector instead of letting the counter wrap back to 0.
          if (r_vec == VEC_MAX) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == '0);
          end else begin
            r_vec   <= w_vec_next;
            r_state <= DRIVE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_count  = r_err;
  assign fail_a     = r_fail_a;
  assign fail_b     = r_fail_b;
  assign fail_cin   = r_fail_cin;
  assign fail_valid = r_fail_valid;

endmodule
